// File: rtl/cond_check_unit.sv
// Multi-lane ARM condition evaluator with its own {Z,C,N,V} status register,
// same-cycle flag bypass, registered results and a saturating skip counter.
module cond_check_unit #(
    parameter int LANES = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flag_we,
    input  logic [3:0]           flag_in,
    input  logic [LANES-1:0]     in_valid,
    input  logic [4*LANES-1:0]   cond_in,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 clr_count,
    output logic [3:0]           status_out,
    output logic [LANES-1:0]     out_valid,
    output logic [LANES-1:0]     cond_pass,
    output logic [CNT_W-1:0]     skip_count
);

    localparam int SUM_W = CNT_W + 3;

    logic [3:0]       status_q;
    logic [3:0]       eff;
    logic [LANES-1:0] pass;
    logic [LANES-1:0] fail;
    logic [SUM_W-1:0] fail_cnt;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] cnt_next;

    function automatic logic eval(input logic [3:0] cond, input logic [3:0] f);
        logic z, c, n, v;
        logic r;
        z = f[3];
        c = f[2];
        n = f[1];
        v = f[0];
        unique case (cond)
            4'h0:    r = z;
            4'h1:    r = ~z;
            4'h2:    r = c;
            4'h3:    r = ~c;
            4'h4:    r = n;
            4'h5:    r = ~n;
            4'h6:    r = v;
            4'h7:    r = ~v;
            4'h8:    r = c & ~z;
            4'h9:    r = ~c | z;
            4'hA:    r = (n == v);
            4'hB:    r = (n != v);
            4'hC:    r = ~z & (n == v);
            4'hD:    r = z | (n != v);
            4'hE:    r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // A flag write in this cycle is visible to this cycle's lanes.
    always_comb eff = flag_we ? flag_in : status_q;

    always_comb begin
        pass     = '0;
        fail     = '0;
        fail_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            pass[i]  = in_valid[i] & eval(cond_in[4*i +: 4], eff);
            fail[i]  = in_valid[i] & ~pass[i];
            fail_cnt = fail_cnt + SUM_W'(fail[i]);
        end
    end

    // Widened add so the saturation compare cannot itself overflow.
    always_comb begin
        sum = SUM_W'(skip_count) + fail_cnt;
        if (sum > SUM_W'({CNT_W{1'b1}}))
            cnt_next = '1;
        else
            cnt_next = sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            status_q <= '0;
        else if (flag_we)
            status_q <= flag_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= '0;
            cond_pass <= '0;
        end else if (flush) begin
            out_valid <= '0;
            cond_pass <= '0;
        end else if (!stall) begin
            out_valid <= in_valid;
            cond_pass <= pass;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            skip_count <= '0;
        else if (clr_count)
            skip_count <= '0;
        else if (!flush && !stall)
            skip_count <= cnt_next;
    end

    assign status_out = status_q;

endmodule
